// File: rtl/atm_pkg.sv
// Shared op codes, response status codes and FSM state encoding for the account arbiter.
package atm_pkg;

  typedef enum logic [1:0] {
    OP_INV = 2'b00,
    OP_DEP = 2'b01,
    OP_WDR = 2'b10,
    OP_QRY = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_INSUF = 2'b01,
    ST_OVF   = 2'b10,
    ST_INV   = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr wins, one-hot out.
module rr_arbiter #(
  parameter int N_TERM = 4,
  parameter int PW     = 2
) (
  input  logic [N_TERM-1:0] i_req,
  input  logic [PW-1:0]     i_ptr,
  output logic [N_TERM-1:0] o_gnt
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N_TERM; i++) begin
      w_idx = (int'(i_ptr) + i) % N_TERM;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/account_arbiter.sv
// Shared-account arbiter: grants ATM terminals round-robin, applies one transaction
// per grant to a single balance and holds the response until ack or timeout.
//   state  | meaning
//   S_IDLE | waiting for a request; grant and latch op/amount on the first one seen
//   S_EXEC | apply latched op to the balance, build the response
//   S_RESP | hold response until granted terminal acks or the ack timer expires
module account_arbiter
  import atm_pkg::*;
#(
  parameter int N_TERM      = 4,
  parameter int AMT_W       = 5,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_TERM-1:0]       req,
  input  logic [2*N_TERM-1:0]     op,
  input  logic [AMT_W*N_TERM-1:0] amount,
  output logic [N_TERM-1:0]       gnt,
  output logic                    resp_valid,
  output logic [1:0]              resp_status,
  output logic [AMT_W-1:0]        resp_balance,
  input  logic [N_TERM-1:0]       resp_ack,
  output logic                    timeout_err
);

  localparam int PW = (N_TERM > 1) ? $clog2(N_TERM) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e             r_state, w_state_nx;
  logic [N_TERM-1:0]  r_gnt, w_gnt_nx;
  logic [PW-1:0]      r_ptr, w_ptr_nx;
  op_e                r_op, w_op_nx;
  logic [AMT_W-1:0]   r_amt, w_amt_nx;
  logic [AMT_W-1:0]   r_bal, w_bal_nx;
  logic               r_rv, w_rv_nx;
  logic [1:0]         r_st, w_st_nx;
  logic [AMT_W-1:0]   r_rbal, w_rbal_nx;
  logic [TW-1:0]      r_tmr, w_tmr_nx;
  logic               r_tout, w_tout_nx;

  logic [N_TERM-1:0]  w_arb_gnt;
  logic [1:0]         w_sel_op;
  logic [AMT_W-1:0]   w_sel_amt;
  logic [PW-1:0]      w_sel_idx;
  logic [PW-1:0]      w_ptr_inc;
  logic [AMT_W:0]     w_sum;
  logic               w_ack;

  rr_arbiter #(.N_TERM(N_TERM), .PW(PW)) u_rr (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt)
  );

  always_comb begin
    w_sel_op  = '0;
    w_sel_amt = '0;
    w_sel_idx = '0;
    for (int i = 0; i < N_TERM; i++) begin
      if (w_arb_gnt[i]) begin
        w_sel_op  = op[2*i +: 2];
        w_sel_amt = amount[AMT_W*i +: AMT_W];
        w_sel_idx = PW'(i);
      end
    end
  end

  assign w_ptr_inc = (w_sel_idx == PW'(N_TERM - 1)) ? '0 : w_sel_idx + 1'b1;
  assign w_sum     = {1'b0, r_bal} + {1'b0, r_amt};
  assign w_ack     = |(resp_ack & r_gnt);

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_ptr_nx   = r_ptr;
    w_op_nx    = r_op;
    w_amt_nx   = r_amt;
    w_bal_nx   = r_bal;
    w_rv_nx    = r_rv;
    w_st_nx    = r_st;
    w_rbal_nx  = r_rbal;
    w_tmr_nx   = r_tmr;
    w_tout_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_gnt_nx   = w_arb_gnt;
          w_ptr_nx   = w_ptr_inc;
          w_op_nx    = op_e'(w_sel_op);
          w_amt_nx   = w_sel_amt;
          w_state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        w_st_nx = ST_OK;
        case (r_op)
          OP_DEP: begin
            if (r_amt == '0)    w_st_nx  = ST_INV;
            else if (w_sum[AMT_W]) w_st_nx = ST_OVF;
            else                w_bal_nx = w_sum[AMT_W-1:0];
          end
          OP_WDR: begin
            if (r_amt == '0)    w_st_nx  = ST_INV;
            else if (r_amt > r_bal) w_st_nx = ST_INSUF;
            else                w_bal_nx = r_bal - r_amt;
          end
          OP_QRY:  w_st_nx = ST_OK;
          default: w_st_nx = ST_INV;
        endcase
        w_rbal_nx  = w_bal_nx;
        w_rv_nx    = 1'b1;
        w_tmr_nx   = TW'(ACK_TIMEOUT - 1);
        w_state_nx = S_RESP;
      end
      S_RESP: begin
        // Ack is checked before expiry so a last-cycle ack still counts.
        if (w_ack || r_tmr == '0) begin
          w_tout_nx  = !w_ack;
          w_gnt_nx   = '0;
          w_rv_nx    = 1'b0;
          w_state_nx = S_IDLE;
        end else begin
          w_tmr_nx = r_tmr - 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_op    <= OP_INV;
      r_amt   <= '0;
      r_bal   <= '0;
      r_rv    <= 1'b0;
      r_st    <= ST_OK;
      r_rbal  <= '0;
      r_tmr   <= '0;
      r_tout  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_ptr   <= w_ptr_nx;
      r_op    <= w_op_nx;
      r_amt   <= w_amt_nx;
      r_bal   <= w_bal_nx;
      r_rv    <= w_rv_nx;
      r_st    <= w_st_nx;
      r_rbal  <= w_rbal_nx;
      r_tmr   <= w_tmr_nx;
      r_tout  <= w_tout_nx;
    end
  end

  assign gnt          = r_gnt;
  assign resp_valid   = r_rv;
  assign resp_status  = r_st;
  assign resp_balance = r_rbal;
  assign timeout_err  = r_tout;

endmodule

// File: tb/tb_account_arbiter.sv
// Directed bench for account_arbiter: hand-computed balances, grants, latency and timeouts.
module tb_account_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  op = '0;
  logic [19:0] amount = '0;
  logic [3:0]  gnt;
  logic        resp_valid;
  logic [1:0]  resp_status;
  logic [4:0]  resp_balance;
  logic [3:0]  resp_ack = '0;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  account_arbiter #(.N_TERM(4), .AMT_W(5), .ACK_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .op           (op),
    .amount       (amount),
    .gnt          (gnt),
    .resp_valid   (resp_valid),
    .resp_status  (resp_status),
    .resp_balance (resp_balance),
    .resp_ack     (resp_ack),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Raises one request, scrambles its op/amount once granted, returns observed response.
  task automatic issue(input int t, input logic [1:0] o, input logic [4:0] a,
                       output logic [3:0] g, output int lat,
                       output logic [1:0] st, output logic [4:0] bal);
    req[t] = 1'b1;
    op[2*t +: 2] = o;
    amount[5*t +: 5] = a;
    g = '0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      if (gnt != '0 && g == '0) begin
        g = gnt;
        req[t] = 1'b0;
        op[2*t +: 2] = ~o;
        amount[5*t +: 5] = ~a;
      end
      if (resp_valid) break;
    end
    st = resp_status;
    bal = resp_balance;
  endtask

  task automatic do_ack(input int t, output logic [3:0] g, output logic rv);
    resp_ack[t] = 1'b1;
    @(posedge clk); #1;
    g = gnt;
    rv = resp_valid;
    resp_ack = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt, resp_valid, resp_status, resp_balance, timeout_err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b rv=%b st=%b bal=%0d to=%b exp all zero",
               gnt, resp_valid, resp_status, resp_balance, timeout_err);
    end
    rst_n = 1'b1;
  endtask

  // One full transaction with expected grant, status and balance, then ack.
  task automatic txn(input string nm, input int t, input logic [1:0] o, input logic [4:0] a,
                     input logic [1:0] exp_st, input logic [4:0] exp_bal);
    logic [3:0] g, g2;
    logic [1:0] st;
    logic [4:0] bal;
    logic rv;
    int lat;
    issue(t, o, a, g, lat, st, bal);
    checks++;
    if (g !== 4'(1 << t)) begin
      errors++;
      $display("FAIL %s_gnt got %b exp %b", nm, g, 4'(1 << t));
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL %s_latency got %0d exp 2", nm, lat);
    end
    checks++;
    if (st !== exp_st) begin
      errors++;
      $display("FAIL %s_status got %b exp %b", nm, st, exp_st);
    end
    checks++;
    if (bal !== exp_bal) begin
      errors++;
      $display("FAIL %s_balance got %0d exp %0d", nm, bal, exp_bal);
    end
    do_ack(t, g2, rv);
    checks++;
    if ({g2, rv} !== 5'd0) begin
      errors++;
      $display("FAIL %s_ack_clear got gnt=%b rv=%b exp 0", nm, g2, rv);
    end
  endtask

  task automatic test_deposit();
    txn("dep10", 0, 2'b01, 5'd10, 2'b00, 5'd10);
  endtask

  task automatic test_withdraw();
    txn("wdr_equal", 0, 2'b10, 5'd10, 2'b00, 5'd0);
    txn("wdr_insuf", 0, 2'b10, 5'd1, 2'b01, 5'd0);
  endtask

  task automatic test_overflow();
    txn("dep30", 2, 2'b01, 5'd30, 2'b00, 5'd30);
    txn("dep_ovf", 2, 2'b01, 5'd5, 2'b10, 5'd30);
    txn("dep_max", 3, 2'b01, 5'd1, 2'b00, 5'd31);
    txn("wdr1", 3, 2'b10, 5'd1, 2'b00, 5'd30);
  endtask

  task automatic test_invalid();
    txn("op00", 1, 2'b00, 5'd3, 2'b11, 5'd30);
    txn("dep_zero", 1, 2'b01, 5'd0, 2'b11, 5'd30);
    txn("wdr_zero", 1, 2'b10, 5'd0, 2'b11, 5'd30);
    txn("query", 1, 2'b11, 5'd7, 2'b00, 5'd30);
  endtask

  task automatic test_ack_ignore();
    logic [3:0] g;
    logic [1:0] st;
    logic [4:0] bal;
    logic rv;
    int lat;
    issue(0, 2'b11, 5'd0, g, lat, st, bal);
    resp_ack = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({resp_valid, gnt, resp_status, resp_balance} !== {1'b1, 4'b0001, 2'b00, 5'd30}) begin
        errors++;
        $display("FAIL other_ack_ignored got rv=%b gnt=%b st=%b bal=%0d exp 1 0001 00 30",
                 resp_valid, gnt, resp_status, resp_balance);
      end
    end
    resp_ack = '0;
    do_ack(0, g, rv);
    checks++;
    if ({g, rv} !== 5'd0) begin
      errors++;
      $display("FAIL other_ack_final got gnt=%b rv=%b exp 0", g, rv);
    end
  endtask

  task automatic test_round_robin();
    int cnt;
    logic [3:0] exp_g;
    pulse_reset();
    op = 8'hFF;
    amount = {4{5'd1}};
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'(1 << (k % 4));
      cnt = 0;
      while (!resp_valid && cnt < 10) begin
        @(posedge clk); #1;
        cnt++;
      end
      checks++;
      if (cnt !== 2) begin
        errors++;
        $display("FAIL rr_latency_%0d got %0d exp 2", k, cnt);
      end
      checks++;
      if (gnt !== exp_g || !$onehot(gnt)) begin
        errors++;
        $display("FAIL rr_grant_%0d got %b exp %b", k, gnt, exp_g);
      end
      checks++;
      if ({resp_status, resp_balance} !== 7'd0) begin
        errors++;
        $display("FAIL rr_resp_%0d got st=%b bal=%0d exp 00 0", k, resp_status, resp_balance);
      end
      resp_ack = exp_g;
      @(posedge clk); #1;
      resp_ack = '0;
      if (k == 4) req = '0;
      checks++;
      if ({gnt, resp_valid} !== 5'd0) begin
        errors++;
        $display("FAIL rr_ack_clear_%0d got gnt=%b rv=%b exp 0", k, gnt, resp_valid);
      end
    end
    op = '0;
    amount = '0;
  endtask

  task automatic test_timeout();
    int cnt;
    logic [3:0] g;
    logic rv;
    pulse_reset();
    req = 4'b0110;
    op = 8'b00_11_01_00;
    amount = {5'd0, 5'd0, 5'd2, 5'd0};
    cnt = 0;
    while (!resp_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
      if (gnt[1]) req[1] = 1'b0;
    end
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL to_first_grant got %b exp 0010", gnt);
    end
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (resp_valid) cnt++;
      else break;
    end
    checks++;
    if (cnt !== 8) begin
      errors++;
      $display("FAIL to_resp_cycles got %0d exp 8", cnt);
    end
    checks++;
    if ({timeout_err, gnt, resp_valid} !== {1'b1, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL to_pulse got to=%b gnt=%b rv=%b exp 1 0000 0", timeout_err, gnt, resp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({timeout_err, gnt} !== {1'b0, 4'b0100}) begin
      errors++;
      $display("FAIL to_next_grant got to=%b gnt=%b exp 0 0100", timeout_err, gnt);
    end
    req[2] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({resp_valid, resp_status, resp_balance} !== {1'b1, 2'b00, 5'd2}) begin
      errors++;
      $display("FAIL to_balance_stands got rv=%b st=%b bal=%0d exp 1 00 2",
               resp_valid, resp_status, resp_balance);
    end
    do_ack(2, g, rv);
    op = '0;
    amount = '0;
  endtask

  task automatic test_ack_at_expiry();
    logic [3:0] g;
    logic [1:0] st;
    logic [4:0] bal;
    int lat;
    issue(0, 2'b11, 5'd0, g, lat, st, bal);
    repeat (7) begin
      @(posedge clk); #1;
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL expiry_still_valid got rv=%b exp 1", resp_valid);
    end
    resp_ack[0] = 1'b1;
    @(posedge clk); #1;
    resp_ack = '0;
    checks++;
    if ({timeout_err, resp_valid, gnt} !== 6'd0) begin
      errors++;
      $display("FAIL expiry_ack_wins got to=%b rv=%b gnt=%b exp 0", timeout_err, resp_valid, gnt);
    end
    @(posedge clk); #1;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL expiry_no_pulse got to=%b exp 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] g;
    logic [1:0] st;
    logic [4:0] bal;
    int lat;
    issue(3, 2'b01, 5'd4, g, lat, st, bal);
    checks++;
    if ({resp_valid, bal} !== {1'b1, 5'd6}) begin
      errors++;
      $display("FAIL mid_pre_balance got rv=%b bal=%0d exp 1 6", resp_valid, bal);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, resp_valid, resp_status, resp_balance, timeout_err} !== 13'd0) begin
      errors++;
      $display("FAIL mid_async_reset got gnt=%b rv=%b st=%b bal=%0d to=%b exp all zero",
               gnt, resp_valid, resp_status, resp_balance, timeout_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn("post_reset_query", 0, 2'b11, 5'd0, 2'b00, 5'd0);
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_deposit();
    test_withdraw();
    test_overflow();
    test_invalid();
    test_ack_ignore();
    test_round_robin();
    test_timeout();
    test_ack_at_expiry();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/account_arbiter.md
ACCOUNT_ARBITER -- requirements
Module: account_arbiter

Interface
REQ-001 SHALL have parameter N_TERM, default 4, number of ATM terminals sharing one account.
REQ-002 SHALL have parameter AMT_W, default 5, width of amount and balance.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 8, cycles to wait for response acknowledge.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  N_TERM  per-terminal transaction request, level, held until granted.
REQ-007 SHALL have port op  input  2*N_TERM  per-terminal op: 00 invalid, 01 deposit, 10 withdraw, 11 balance query.
REQ-008 SHALL have port amount  input  AMT_W*N_TERM  per-terminal transaction amount.
REQ-009 SHALL have port gnt  output  N_TERM  one-hot grant, at most one bit set.
REQ-010 SHALL have port resp_valid  output  1  response available to granted terminal.
REQ-011 SHALL have port resp_status  output  2  00 ok, 01 insufficient funds, 10 overflow, 11 invalid op/zero amount.
REQ-012 SHALL have port resp_balance  output  AMT_W  account balance after the transaction.
REQ-013 SHALL have port resp_ack  input  N_TERM  per-terminal response acknowledge.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse when a response is abandoned.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 IDLE: if any req bit set, SHALL grant round-robin starting from the terminal after the last granted, set gnt, latch that terminal's op and amount, go EXEC next cycle.
REQ-017 Grant pointer SHALL wrap from N_TERM-1 to 0; a lone requester SHALL be granted repeatedly.
REQ-018 EXEC (one cycle): deposit SHALL add amount; status overflow and balance unchanged if sum exceeds 2^AMT_W-1.
REQ-019 EXEC: withdraw SHALL subtract amount if amount <= balance (equal allowed, result 0), else status insufficient funds and balance unchanged.
REQ-020 EXEC: balance query SHALL leave balance unchanged with status ok; op 00 or zero amount on deposit/withdraw SHALL give status invalid.
REQ-021 Latency SHALL be fixed: resp_valid asserts exactly 2 cycles after the IDLE cycle in which req is sampled.
REQ-022 RESP: resp_valid, resp_status, resp_balance SHALL be held stable until the granted terminal's resp_ack is high; ack bits of other terminals SHALL be ignored.
REQ-023 On ack, gnt and resp_valid SHALL clear next cycle and FSM SHALL return to IDLE; a new grant is possible the cycle after.
REQ-024 RESP SHALL count cycles; after ACK_TIMEOUT cycles without ack SHALL pulse timeout_err, clear gnt/resp_valid, return IDLE; the balance update already applied SHALL stand.
REQ-025 Requests changing or dropping while not granted SHALL have no effect; op/amount changes after latching SHALL be ignored.
REQ-026 Ack arriving in the same cycle as timeout expiry SHALL be treated as ack (no timeout_err).

Reset
REQ-027 rst_n low SHALL immediately force FSM to IDLE, gnt=0, resp_valid=0, resp_status=00, resp_balance=0, timeout_err=0, balance=0, grant pointer so terminal 0 is first priority.
REQ-028 Reset mid-transaction SHALL discard the transaction; a balance update applied in EXEC before reset is lost with the reset to 0.

Structure
REQ-029 Op codes, status codes and FSM state encoding SHALL live in shared package atm_pkg.
REQ-030 Round-robin selection SHALL be one sub-module rr_arbiter (req, pointer in, one-hot grant out, combinational).

Verification
REQ-031 Reset, single terminal 0 deposit 10 -> gnt=0001, resp_valid 2 cycles later, status ok, balance 10.
REQ-032 Balance 10, withdraw 10 -> status ok, balance 0; then withdraw 1 -> status insufficient, balance 0.
REQ-033 Balance 30, deposit 5 (AMT_W=5) -> status overflow, balance 30.
REQ-034 All four req held with balance queries -> grants 0,1,2,3,0 in order, one-hot, each acked.
REQ-035 No resp_ack for 8 cycles in RESP -> timeout_err one-cycle pulse, gnt 0, next requester granted.
REQ-036 rst_n low during RESP -> all outputs 0 asynchronously, FSM IDLE, balance 0.
